// File: rtl/gemm_out_drain.sv
// gemm_out_drain: streams one finished accumulator tile out row by row through a small FWFT FIFO.
// Optional GEMM_DRAIN_RELU_EN: clamps negative elements to zero as rows enter the FIFO.
module gemm_out_drain #(
    parameter int SYS_ARRAY_SIZE = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ACC_RD_LATENCY = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  output_valid,
    output logic                                  acc_rd_en,
    output logic [$clog2(SYS_ARRAY_SIZE)-1:0]     acc_rd_addr,
    input  logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0]  acc_rd_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0]  out_data,
    output logic                                  out_last,
    output logic                                  drain_busy,
    output logic                                  drain_done,
    output logic                                  drain_overrun
);

    localparam int ROW_W = SYS_ARRAY_SIZE * DATA_WIDTH;
    localparam int AW    = $clog2(SYS_ARRAY_SIZE);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int IW    = $clog2(ACC_RD_LATENCY + 1);
    localparam int SW    = $clog2(FIFO_DEPTH + ACC_RD_LATENCY + 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(SYS_ARRAY_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        DONE
    } state_t;

    state_t state, state_next;

    logic                      ov_prev;
    logic                      rise;
    logic [ACC_RD_LATENCY-1:0] rd_vld_sr;
    logic [ACC_RD_LATENCY-1:0] rd_last_sr;
    logic [IW-1:0]             inflight;
    logic                      credit;

    logic [ROW_W-1:0]          mem_data [FIFO_DEPTH];
    logic                      mem_last [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic [ROW_W-1:0]          push_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rise       = output_valid & ~ov_prev;
    assign fifo_empty = (fifo_count == '0);
    assign push       = rd_vld_sr[ACC_RD_LATENCY-1];
    assign pop        = out_valid & out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ACC_RD_LATENCY; i++) begin
            inflight = inflight + IW'(rd_vld_sr[i]);
        end
    end

    // Credit counts only registered occupancy, so a same-cycle pop never frees a slot early.
    assign credit = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        acc_rd_en  = 1'b0;
        case (state)
            IDLE: if (rise) state_next = READ;
            READ: begin
                acc_rd_en = credit;
                if (credit && acc_rd_addr == LAST_ROW) state_next = WAIT;
            end
            WAIT: if (pop && out_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ov_prev       <= 1'b0;
            drain_overrun <= 1'b0;
            acc_rd_addr   <= '0;
            rd_vld_sr     <= '0;
            rd_last_sr    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
        end else begin
            ov_prev <= output_valid;
            if (rise && state != IDLE) drain_overrun <= 1'b1;

            if (state == IDLE) begin
                acc_rd_addr <= '0;
            end else if (acc_rd_en) begin
                acc_rd_addr <= acc_rd_addr + 1'b1;
            end

            for (int i = ACC_RD_LATENCY - 1; i > 0; i--) begin
                rd_vld_sr[i]  <= rd_vld_sr[i-1];
                rd_last_sr[i] <= rd_last_sr[i-1];
            end
            rd_vld_sr[0]  <= acc_rd_en;
            rd_last_sr[0] <= acc_rd_en && (acc_rd_addr == LAST_ROW);

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

`ifdef GEMM_DRAIN_RELU_EN
    always_comb begin
        push_data = acc_rd_data;
        for (int e = 0; e < SYS_ARRAY_SIZE; e++) begin
            if (acc_rd_data[e*DATA_WIDTH + DATA_WIDTH - 1]) begin
                push_data[e*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end
`else
    assign push_data = acc_rd_data;
`endif

    // NOTE: row storage is not reset; the empty flag alone decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= rd_last_sr[ACC_RD_LATENCY-1];
        end
    end

    // Gate the head entry so stale storage never reaches the stream while empty.
    assign out_valid  = ~fifo_empty;
    assign out_data   = fifo_empty ? '0 : mem_data[rd_ptr];
    assign out_last   = ~fifo_empty & mem_last[rd_ptr];

    assign drain_busy = (state != IDLE);
    assign drain_done = (state == DONE);

endmodule

// File: tb/tb_gemm_out_drain.sv
// tb_gemm_out_drain: randomized self-checking bench; the accumulator buffer and the expected
// row stream are modelled behaviourally (tile rows 0..N-1 in order, optional ReLU clamp).
module tb_gemm_out_drain;

    localparam int N     = 32;
    localparam int DW    = 32;
    localparam int L     = 2;
    localparam int D     = 4;
    localparam int ROW_W = N * DW;
    localparam int AW    = $clog2(N);

    logic             clk = 1'b0;
    logic             reset;
    logic             output_valid;
    logic             acc_rd_en;
    logic [AW-1:0]    acc_rd_addr;
    logic [ROW_W-1:0] acc_rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic             out_last;
    logic             drain_busy;
    logic             drain_done;
    logic             drain_overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    gemm_out_drain #(
        .SYS_ARRAY_SIZE(N),
        .DATA_WIDTH    (DW),
        .ACC_RD_LATENCY(L),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .output_valid (output_valid),
        .acc_rd_en    (acc_rd_en),
        .acc_rd_addr  (acc_rd_addr),
        .acc_rd_data  (acc_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .drain_busy   (drain_busy),
        .drain_done   (drain_done),
        .drain_overrun(drain_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Accumulator buffer model: the row addressed L cycles ago appears on acc_rd_data.
    logic [DW-1:0] acc_mem [N][N];
    bit            h_en   [L+1];
    int            h_addr [L+1];

    initial begin
        for (int i = 0; i <= L; i++) begin
            h_en[i]   = 1'b0;
            h_addr[i] = 0;
        end
        acc_rd_data = '0;
    end

    function automatic logic [ROW_W-1:0] acc_row(input int r);
        logic [ROW_W-1:0] v;
        for (int e = 0; e < N; e++) v[e*DW +: DW] = acc_mem[r][e];
        return v;
    endfunction

    always @(negedge clk) begin
        for (int i = L; i > 0; i--) begin
            h_en[i]   = h_en[i-1];
            h_addr[i] = h_addr[i-1];
        end
        h_en[0]   = acc_rd_en;
        h_addr[0] = int'(acc_rd_addr);
        if (h_en[L]) begin
            acc_rd_data = acc_row(h_addr[L]);
        end else begin
            for (int e = 0; e < N; e++) acc_rd_data[e*DW +: DW] = $urandom;
        end
    end

    // Reference: the stream must be rows 0..N-1 in order, element-wise clamped when ReLU is built in.
    function automatic logic [ROW_W-1:0] expected_row(input int r);
        logic [ROW_W-1:0] v;
        logic [DW-1:0]    x;
        for (int e = 0; e < N; e++) begin
            x = acc_mem[r][e];
`ifdef GEMM_DRAIN_RELU_EN
            if ($signed(x) < 0) x = '0;
`endif
            v[e*DW +: DW] = x;
        end
        return v;
    endfunction

    // Observation record filled once per cycle.
    logic [ROW_W-1:0] beat_data [$];
    bit               beat_last [$];
    int               beat_cyc  [$];
    int               issue_addr[$];
    int               issue_cyc [$];
    int               done_cyc  [$];
    int               stab_viol;
    int               busy_cycles;
    bit               was_stalled;
    logic [ROW_W-1:0] prev_data;
    logic             prev_last;

    task automatic clear_obs();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        issue_addr.delete();
        issue_cyc.delete();
        done_cyc.delete();
        stab_viol   = 0;
        busy_cycles = 0;
        was_stalled = 1'b0;
    endtask

    // One clock: sample outputs at negedge, then drive this cycle's inputs.
    task automatic cyc_step(input bit rdy, input bit ov, input bit rst);
        @(negedge clk);
        reset        = rst;
        output_valid = ov;
        out_ready    = rdy;
        if (acc_rd_en) begin
            issue_addr.push_back(int'(acc_rd_addr));
            issue_cyc.push_back(cyc);
        end
        if (drain_done) done_cyc.push_back(cyc);
        if (drain_busy) busy_cycles++;
        if (was_stalled && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stab_viol++;
        if (out_valid && rdy && !rst) begin
            beat_data.push_back(out_data);
            beat_last.push_back(out_last);
            beat_cyc.push_back(cyc);
        end
        was_stalled = out_valid && !rdy && !rst;
        prev_data   = out_data;
        prev_last   = out_last;
    endtask

    // Runs until the drain has completed and busy has dropped; returns 1 on budget expiry.
    task automatic run_until_idle(input bit rand_ready, input bit ov, input int budget,
                                  output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cyc_step(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, ov, 1'b0);
            if (done_cyc.size() > 0 && !drain_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    function automatic int payload_errs();
        int n = 0;
        for (int k = 0; k < beat_data.size() && k < N; k++) begin
            if (beat_data[k] !== expected_row(k) || beat_last[k] !== (k == N - 1)) n++;
        end
        return n;
    endfunction

    function automatic int issue_order_errs();
        int n = 0;
        for (int k = 0; k < issue_addr.size(); k++) if (issue_addr[k] != k) n++;
        return n;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < N; r++) for (int e = 0; e < N; e++) acc_mem[r][e] = $urandom;
    endtask

    task automatic trigger(input bit rdy);
        cyc_step(rdy, 1'b0, 1'b0);
        cyc_step(rdy, 1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({acc_rd_en, acc_rd_addr, out_valid, out_last, drain_busy, drain_done, drain_overrun} !== '0) begin
            errors++;
            $display("FAIL %s ctrl outputs: got en=%b addr=%0d v=%b last=%b busy=%b done=%b ovr=%b, want all 0",
                     tag, acc_rd_en, acc_rd_addr, out_valid, out_last, drain_busy, drain_done, drain_overrun);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL %s out_data: got nonzero (low word %h), want 0", tag, out_data[DW-1:0]);
        end
    endtask

    task automatic test_reset();
        cyc_step(1'b0, 1'b0, 1'b1);
        cyc_step(1'b0, 1'b0, 1'b1);
        cyc_step(1'b0, 1'b0, 1'b0);
        check_all_zero("reset");
    endtask

    task automatic test_basic();
        int t;
        bit to;
        int gaps = 0;
        for (int r = 0; r < N; r++) for (int e = 0; e < N; e++) acc_mem[r][e] = DW'(r * 32 + e);
        clear_obs();
        trigger(1'b1);
        t = cyc;
        run_until_idle(1'b0, 1'b1, 80, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic timeout: drain did not finish in 80 cycles"); end
        checks++;
        if (beat_data.size() != N) begin
            errors++; $display("FAIL basic beats: got %0d, want %0d", beat_data.size(), N);
        end
        checks++;
        if (payload_errs() != 0) begin
            errors++; $display("FAIL basic payload: %0d bad beats, want 0", payload_errs());
        end
        for (int k = 0; k < beat_cyc.size(); k++) if (beat_cyc[k] != t + 4 + k) gaps++;
        checks++;
        if (gaps != 0 || beat_cyc.size() == 0 || beat_cyc[0] != t + 4) begin
            errors++;
            $display("FAIL basic beat timing: %0d misplaced beats, first at t+%0d, want t+4 contiguous",
                     gaps, beat_cyc.size() ? beat_cyc[0] - t : -1);
        end
        checks++;
        if (issue_addr.size() != N || issue_order_errs() != 0 || issue_cyc[0] != t + 1) begin
            errors++;
            $display("FAIL basic reads: got %0d issues first at t+%0d, want %0d in order from t+1",
                     issue_addr.size(), issue_cyc.size() ? issue_cyc[0] - t : -1, N);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t + 36) begin
            errors++;
            $display("FAIL basic done: got %0d pulses first at t+%0d, want 1 at t+36",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] - t : -1);
        end
        checks++;
        if (cyc != t + 37) begin
            errors++; $display("FAIL basic idle: busy dropped at t+%0d, want t+37", cyc - t);
        end
        // Level held high must not start another tile.
        clear_obs();
        repeat (20) cyc_step(1'b1, 1'b1, 1'b0);
        checks++;
        if (busy_cycles != 0 || issue_addr.size() != 0) begin
            errors++;
            $display("FAIL basic retrigger: got %0d busy cycles %0d reads, want 0",
                     busy_cycles, issue_addr.size());
        end
        cyc_step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int rel;
        bit to;
        fill_random();
        clear_obs();
        trigger(1'b0);
        repeat (20) cyc_step(1'b0, 1'b1, 1'b0);
        rel = cyc;
        checks++;
        if (issue_addr.size() != D || issue_order_errs() != 0) begin
            errors++; $display("FAIL stall reads: got %0d issued, want %0d", issue_addr.size(), D);
        end
        checks++;
        if (out_valid !== 1'b1 || beat_data.size() != 0) begin
            errors++; $display("FAIL stall head: out_valid=%b beats=%0d, want 1 and 0", out_valid, beat_data.size());
        end
        run_until_idle(1'b0, 1'b1, 100, to);
        checks++;
        if (to || issue_cyc.size() <= D || issue_cyc[D] != rel + 2) begin
            errors++;
            $display("FAIL stall resume: to=%b next read at rel+%0d, want rel+2", to,
                     issue_cyc.size() > D ? issue_cyc[D] - rel : -1);
        end
        checks++;
        if (beat_data.size() != N || payload_errs() != 0) begin
            errors++;
            $display("FAIL stall stream: got %0d beats %0d bad, want %0d and 0", beat_data.size(), payload_errs(), N);
        end
        checks++;
        if (issue_addr.size() != N || issue_order_errs() != 0 || stab_viol != 0) begin
            errors++;
            $display("FAIL stall reads/stability: got %0d reads %0d unstable, want %0d and 0",
                     issue_addr.size(), stab_viol, N);
        end
        cyc_step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit to;
        for (int tile = 0; tile < 3; tile++) begin
            fill_random();
            clear_obs();
            trigger(1'($urandom_range(0, 1)));
            run_until_idle(1'b1, 1'b1, 400, to);
            checks++;
            if (to || beat_data.size() != N) begin
                errors++;
                $display("FAIL b2b tile%0d beats: to=%b got %0d, want %0d", tile, to, beat_data.size(), N);
            end
            checks++;
            if (payload_errs() != 0) begin
                errors++; $display("FAIL b2b tile%0d payload: %0d bad beats, want 0", tile, payload_errs());
            end
            checks++;
            if (stab_viol != 0) begin
                errors++; $display("FAIL b2b tile%0d stability: %0d changes while stalled, want 0", tile, stab_viol);
            end
            checks++;
            if (done_cyc.size() != 1) begin
                errors++; $display("FAIL b2b tile%0d done: got %0d pulses, want 1", tile, done_cyc.size());
            end
        end
        cyc_step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        bit to;
        checks++;
        if (drain_overrun !== 1'b0) begin
            errors++; $display("FAIL overrun pre: got %b, want 0", drain_overrun);
        end
        fill_random();
        clear_obs();
        trigger(1'b1);
        repeat (4) cyc_step(1'b1, 1'b1, 1'b0);
        cyc_step(1'b1, 1'b0, 1'b0);
        cyc_step(1'b1, 1'b1, 1'b0);
        run_until_idle(1'b0, 1'b1, 80, to);
        checks++;
        if (drain_overrun !== 1'b1) begin
            errors++; $display("FAIL overrun flag: got %b, want 1", drain_overrun);
        end
        checks++;
        if (to || beat_data.size() != N || payload_errs() != 0 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL overrun drain: to=%b beats=%0d bad=%0d done=%0d, want 0/%0d/0/1",
                     to, beat_data.size(), payload_errs(), done_cyc.size(), N);
        end
        clear_obs();
        repeat (30) cyc_step(1'b1, 1'b1, 1'b0);
        checks++;
        if (busy_cycles != 0 || issue_addr.size() != 0 || drain_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun after: busy=%0d reads=%0d flag=%b, want 0/0/1",
                     busy_cycles, issue_addr.size(), drain_overrun);
        end
        cyc_step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        bit to;
        fill_random();
        clear_obs();
        trigger(1'b1);
        for (int i = 0; i < 100 && beat_data.size() < 10; i++) cyc_step(1'b1, 1'b1, 1'b0);
        checks++;
        if (beat_data.size() != 10) begin
            errors++; $display("FAIL midreset setup: got %0d beats, want 10", beat_data.size());
        end
        cyc_step(1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 1'b0, 1'b0);
        check_all_zero("midreset");
        clear_obs();
        repeat (6) cyc_step(1'b1, 1'b0, 1'b0);
        checks++;
        if (beat_data.size() != 0 || busy_cycles != 0) begin
            errors++;
            $display("FAIL midreset discard: got %0d beats %0d busy, want 0", beat_data.size(), busy_cycles);
        end
        fill_random();
        clear_obs();
        trigger(1'b1);
        run_until_idle(1'b0, 1'b1, 80, to);
        checks++;
        if (to || beat_data.size() != N || payload_errs() != 0 || issue_addr.size() == 0 || issue_addr[0] != 0) begin
            errors++;
            $display("FAIL midreset redrain: to=%b beats=%0d bad=%0d, want 0/%0d/0 from row 0",
                     to, beat_data.size(), payload_errs(), N);
        end
        cyc_step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_relu();
        bit to;
        logic [DW-1:0] want0;
        for (int r = 0; r < N; r++)
            for (int e = 0; e < N; e++) acc_mem[r][e] = (e % 2 == 0) ? -32'sd5 : 32'sd7;
`ifdef GEMM_DRAIN_RELU_EN
        want0 = '0;
`else
        want0 = -32'sd5;
`endif
        clear_obs();
        trigger(1'b1);
        run_until_idle(1'b0, 1'b1, 80, to);
        checks++;
        if (to || beat_data.size() != N) begin
            errors++; $display("FAIL relu beats: to=%b got %0d, want %0d", to, beat_data.size(), N);
        end else begin
            checks++;
            if (beat_data[0][DW-1:0] !== want0) begin
                errors++; $display("FAIL relu elem0: got %0d, want %0d", $signed(beat_data[0][DW-1:0]), $signed(want0));
            end
            checks++;
            if (beat_data[0][2*DW-1:DW] !== 32'd7) begin
                errors++; $display("FAIL relu elem1: got %0d, want 7", $signed(beat_data[0][2*DW-1:DW]));
            end
        end
        checks++;
        if (payload_errs() != 0) begin
            errors++; $display("FAIL relu payload: %0d bad beats, want 0", payload_errs());
        end
        cyc_step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        output_valid = 1'b0;
        out_ready    = 1'b0;
        clear_obs();
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
